subnib_ctrl: RTL and testbench

Sequencer for the S-AES SubNibbles step in the DOM-masked datapath. It latches a two-share 16-bit state, feeds its four nibbles one per cycle through a single shared `SBox` instance with fresh 12-bit randomness per nibble, and collects the pipelined results. It then presents the substituted two-share state with a done pulse. It sits between the round controller and the masked S-box.

---
 rtl/saes_pkg.sv | 25 ++
 rtl/SBox.sv | 46 ++++
 rtl/subnib_ctrl.sv | 159 +++++++++++++++
 tb/tb_subnib_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/saes_pkg.sv
// Shared S-AES definitions for the masked SubNibbles datapath: widths, the
// sequencer state type and the 4-bit substitution table.
package saes_pkg;

    localparam int SBOX_LAT_DEFAULT = 3;
    localparam int NIB_W            = 4;
    localparam int RAND_W           = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [NIB_W-1:0] SBOX_TBL [16] = '{
        4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
        4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
    };

    function automatic logic [NIB_W-1:0] sbox_lookup(input logic [NIB_W-1:0] x);
        return SBOX_TBL[x];
    endfunction

endpackage

// File: rtl/SBox.sv
// Two-share S-AES S-box with a fixed LAT-cycle pipeline and no reset.
// The result is re-masked with a nibble folded from all six randomness pairs,
// so the output shares never reuse the input masks.
module SBox
    import saes_pkg::*;
#(
    parameter int LAT = SBOX_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    input  logic [1:0]       Z0,
    input  logic [1:0]       Z1,
    input  logic [1:0]       Z2,
    input  logic [1:0]       Z3,
    input  logic [1:0]       Z4,
    input  logic [1:0]       Z5,
    output logic [NIB_W-1:0] A_out,
    output logic [NIB_W-1:0] B_out
);

    logic [NIB_W-1:0] mask_c;
    logic [NIB_W-1:0] a_c;
    logic [NIB_W-1:0] a_p [LAT];
    logic [NIB_W-1:0] b_p [LAT];

    // Fresh output mask and substituted share A for the nibble presented now
    always_comb begin
        mask_c = {Z1, Z0} ^ {Z3, Z2} ^ {Z5, Z4};
        a_c    = sbox_lookup(A ^ B) ^ mask_c;
    end

    // Data pipeline carrying both output shares through LAT register stages
    always_ff @(posedge clk) begin
        a_p[0] <= a_c;
        b_p[0] <= mask_c;
        for (int i = 1; i < LAT; i++) begin
            a_p[i] <= a_p[i-1];
            b_p[i] <= b_p[i-1];
        end
    end

    assign A_out = a_p[LAT-1];
    assign B_out = b_p[LAT-1];

endmodule

// File: rtl/subnib_ctrl.sv
// SubNibbles sequencer: latches a two-share state, streams its four nibbles
// through one shared masked S-box (one nibble per fresh randomness word) and
// reassembles the returning shares, tracked by a tag shift register that
// mirrors the S-box latency.
module subnib_ctrl
    import saes_pkg::*;
#(
    parameter int SBOX_LAT = SBOX_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       state_a,
    input  logic [15:0]       state_b,
    input  logic [RAND_W-1:0] rand_in,
    input  logic              rand_valid,
    output logic              rand_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       out_a,
    output logic [15:0]       out_b
);

    state_t           state_q, state_d;
    logic [15:0]      sh_a, sh_b;
    logic [1:0]       issue_cnt;
    logic [2:0]       ret_cnt;
    logic             tag_vld_p [SBOX_LAT];
    logic [1:0]       tag_idx_p [SBOX_LAT];
    logic             accept;
    logic             issue;
    logic             ret_vld;
    logic [1:0]       ret_idx;
    logic [NIB_W-1:0] sbox_a, sbox_b, sbox_a_out, sbox_b_out;
    logic [RAND_W-1:0] sbox_z;

    // idx 0 is the most significant nibble
    function automatic logic [NIB_W-1:0] get_nib(input logic [15:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[15:12];
            2'd1:    return w[11:8];
            2'd2:    return w[7:4];
            default: return w[3:0];
        endcase
    endfunction

    function automatic logic [15:0] put_nib(input logic [15:0] w, input logic [1:0] idx,
                                            input logic [NIB_W-1:0] v);
        logic [15:0] r;
        r = w;
        case (idx)
            2'd0:    r[15:12] = v;
            2'd1:    r[11:8]  = v;
            2'd2:    r[7:4]   = v;
            default: r[3:0]   = v;
        endcase
        return r;
    endfunction

    assign accept  = (state_q == IDLE) && start;
    assign issue   = (state_q == ISSUE) && rand_valid;
    assign ret_vld = tag_vld_p[SBOX_LAT-1] && (state_q != IDLE);
    assign ret_idx = tag_idx_p[SBOX_LAT-1];

    // S-box inputs: live shares only on an issue cycle, zero otherwise
    always_comb begin
        sbox_a = '0;
        sbox_b = '0;
        sbox_z = '0;
        if (issue) begin
            sbox_a = get_nib(sh_a, issue_cnt);
            sbox_b = get_nib(sh_b, issue_cnt);
            sbox_z = rand_in;
        end
    end

    SBox #(.LAT(SBOX_LAT)) u_sbox (
        .clk   (clk),
        .A     (sbox_a),
        .B     (sbox_b),
        .Z0    (sbox_z[1:0]),
        .Z1    (sbox_z[3:2]),
        .Z2    (sbox_z[5:4]),
        .Z3    (sbox_z[7:6]),
        .Z4    (sbox_z[9:8]),
        .Z5    (sbox_z[11:10]),
        .A_out (sbox_a_out),
        .B_out (sbox_b_out)
    );

    // Next-state and status outputs
    always_comb begin
        state_d    = state_q;
        rand_ready = 1'b0;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: begin
                rand_ready = 1'b1;
                if (issue && (issue_cnt == 2'd3)) state_d = DRAIN;
            end
            DRAIN: if (ret_vld && (ret_idx == 2'd3) && (ret_cnt == 3'd3)) state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control: state register, issue/return counters and the latency tag pipe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            issue_cnt <= 2'd0;
            ret_cnt   <= 3'd0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                tag_vld_p[i] <= 1'b0;
                tag_idx_p[i] <= 2'd0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                issue_cnt <= 2'd0;
                ret_cnt   <= 3'd0;
            end else begin
                if (issue)   issue_cnt <= issue_cnt + 2'd1;
                if (ret_vld) ret_cnt   <= ret_cnt + 3'd1;
            end
            tag_vld_p[0] <= issue;
            tag_idx_p[0] <= issue_cnt;
            for (int i = 1; i < SBOX_LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_idx_p[i] <= tag_idx_p[i-1];
            end
        end
    end

    // Input share capture on start acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            sh_a <= state_a;
            sh_b <= state_b;
        end
    end

    // Result shares: write each returning nibble back into its own position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_a <= '0;
            out_b <= '0;
        end else if (ret_vld) begin
            out_a <= put_nib(out_a, ret_idx, sbox_a_out);
            out_b <= put_nib(out_b, ret_idx, sbox_b_out);
        end
    end

endmodule

// File: tb/tb_subnib_ctrl.sv
// Randomized self-checking bench for subnib_ctrl against a nibble-wise
// S-AES substitution model with a cycle-level issue/done schedule.
module tb_subnib_ctrl;

    localparam int LAT = 3;
    localparam logic [3:0] REF_TBL [16] = '{
        4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
        4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] state_a, state_b;
    logic [11:0] rand_in;
    logic        rand_valid;
    logic        rand_ready, busy, done;
    logic [15:0] out_a, out_b;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] prev_a, prev_b;
    bit          have_prev = 1'b0;
    logic [15:0] last_res;

    subnib_ctrl #(.SBOX_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .state_a    (state_a),
        .state_b    (state_b),
        .rand_in    (rand_in),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .busy       (busy),
        .done       (done),
        .out_a      (out_a),
        .out_b      (out_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_subnib(input logic [15:0] x);
        logic [15:0] r;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = REF_TBL[x[4*k +: 4]];
        return r;
    endfunction

    function automatic logic [3:0] nib_at(input logic [15:0] w, input int idx);
        return w[4*(3-idx) +: 4];
    endfunction

    // mode 0: rand_valid always high; 1: random rand_valid plus start noise;
    // 2: rand_valid low for the two cycles after the second issue.
    task automatic run_pass(input logic [15:0] sa, input logic [15:0] sb,
                            input int mode, input int exp_done_c);
        int  issued;
        int  done_c;
        int  low_left;
        bit  seen;
        bit  v;
        state_a    = sa;
        state_b    = sb;
        start      = 1'b1;
        rand_valid = 1'($urandom_range(1));
        rand_in    = 12'($urandom);
        @(negedge clk);
        if (have_prev) begin
            chk("hold_a", 32'(out_a), 32'(prev_a));
            chk("hold_b", 32'(out_b), 32'(prev_b));
        end
        chk("idle_busy",  32'(busy),       32'd0);
        chk("idle_ready", 32'(rand_ready), 32'd0);
        @(posedge clk); #1;
        start    = 1'b0;
        state_a  = 16'($urandom);
        state_b  = 16'($urandom);
        issued   = 0;
        done_c   = -1;
        low_left = 0;
        seen     = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            if (issued < 4) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = ($urandom_range(3) != 0);
                    default: begin
                        if (low_left > 0) begin
                            v = 1'b0;
                            low_left--;
                        end else v = 1'b1;
                    end
                endcase
            end else begin
                v = 1'($urandom_range(1));
            end
            rand_valid = v;
            rand_in    = 12'($urandom);
            start      = (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            chk("busy",  32'(busy),       32'd1);
            chk("ready", 32'(rand_ready), 32'(issued < 4));
            if (issued < 4 && v) begin
                chk("sbox_a", 32'(dut.sbox_a), 32'(nib_at(sa, issued)));
                chk("sbox_b", 32'(dut.sbox_b), 32'(nib_at(sb, issued)));
                chk("sbox_z", 32'(dut.sbox_z), 32'(rand_in));
                issued++;
                if (issued == 4) done_c = c + LAT + 1;
                if (mode == 2 && issued == 2) low_left = 2;
            end else begin
                chk("idle_sbox_a", 32'(dut.sbox_a), 32'd0);
                chk("idle_sbox_b", 32'(dut.sbox_b), 32'd0);
                chk("idle_sbox_z", 32'(dut.sbox_z), 32'd0);
            end
            chk("done", 32'(done), 32'(c == done_c));
            if (done) begin
                seen = 1'b1;
                if (exp_done_c >= 0) chk("done_cycle", 32'(c), 32'(exp_done_c));
                chk("result", 32'(out_a ^ out_b), 32'(ref_subnib(sa ^ sb)));
                prev_a    = out_a;
                prev_b    = out_b;
                have_prev = 1'b1;
                last_res  = out_a ^ out_b;
            end
            @(posedge clk); #1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        start      = 1'b0;
        rand_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] m;
        reset      = 1'b0;
        start      = 1'b0;
        state_a    = '0;
        state_b    = '0;
        rand_in    = '0;
        rand_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_a", 32'(out_a),      32'd0);
        chk("rst_out_b", 32'(out_b),      32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_ready", 32'(rand_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Known vector: every nibble of the recombined state is 5 -> 1
        run_pass(16'h0000, 16'h5555, 0, 8);
        chk("vec_1111", 32'(last_res), 32'h1111);

        // 0x0123 under a random mask
        m = 16'($urandom);
        run_pass(m ^ 16'h0123, m, 1, -1);
        chk("vec_94ab", 32'(last_res), 32'h94AB);

        // Two stalled cycles after the second issue push done out by two
        m = 16'($urandom);
        run_pass(m ^ 16'h0123, m, 2, 10);
        chk("stall_94ab", 32'(last_res), 32'h94AB);

        // Abort two cycles after start
        start   = 1'b1;
        state_a = 16'($urandom);
        state_b = 16'($urandom);
        @(posedge clk); #1;
        start      = 1'b0;
        rand_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_out_a", 32'(out_a),      32'd0);
            chk("abort_out_b", 32'(out_b),      32'd0);
            chk("abort_done",  32'(done),       32'd0);
            chk("abort_busy",  32'(busy),       32'd0);
            chk("abort_ready", 32'(rand_ready), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_abort_done", 32'(done), 32'd0);
            chk("post_abort_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        rand_valid = 1'b0;
        prev_a    = 16'h0000;
        prev_b    = 16'h0000;
        have_prev = 1'b1;
        m = 16'($urandom);
        run_pass(m ^ 16'h0123, m, 0, 8);
        chk("after_abort_94ab", 32'(last_res), 32'h94AB);

        // Random states, masks, randomness and start noise, back to back
        for (int t = 0; t < 1000; t++) begin
            run_pass(16'($urandom), 16'($urandom), 1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
